// File: rtl/debug_unit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : debug_unit_ctrl_if
// Purpose  : Groups the host byte link, the instruction-memory load port and
//            the pipeline control/status signals of debug_unit_ctrl.
// Ports    : slave  - debug-unit side (consumes rx bytes, produces tx bytes,
//                     drives the load port and pipeline enable)
//            master - host / pipeline side (the mirror image of slave)
// Signals  : i_rx_data/i_rx_valid/o_rx_ready   host -> controller bytes
//            o_tx_data/o_tx_valid/i_tx_ready   controller -> host bytes
//            o_instruccion/o_address/o_loading instruction memory write
//            o_enable, i_halt, i_result        pipeline control / status
//            o_done, o_load_err                completion pulse, load error
// Revision : 1.0 - initial release
// ============================================================================
interface debug_unit_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            i_rx_data;
    logic                  i_rx_valid;
    logic                  o_rx_ready;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    logic [DATA_WIDTH-1:0] o_instruccion;
    logic [DATA_WIDTH-1:0] o_address;
    logic                  o_loading;
    logic                  o_enable;
    logic                  i_halt;
    logic [DATA_WIDTH-1:0] i_result;
    logic                  o_done;
    logic                  o_load_err;

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_result,
        output o_rx_ready, o_tx_data, o_tx_valid, o_instruccion, o_address,
               o_loading, o_enable, o_done, o_load_err
    );

    modport master (
        output i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_result,
        input  o_rx_ready, o_tx_data, o_tx_valid, o_instruccion, o_address,
               o_loading, o_enable, o_done, o_load_err
    );
endinterface
`default_nettype wire

// File: rtl/debug_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debug_unit_ctrl
// Purpose  : Host-driven debug sequencer for the MIPS pipeline. Loads a
//            program byte-wise into instruction memory, then runs the
//            pipeline either continuously until halt (reporting the cycle
//            count) or one clock per host request (reporting the write-back
//            value). Reports are 4 bytes, MSB first.
// Ports    : i_clock - system clock, rising edge
//            i_reset - synchronous active-high reset
//            bus     - debug_unit_ctrl_if.slave (host link, load port,
//                      pipeline enable/halt/result, done, load error)
// Revision : 1.0 - initial release
// ============================================================================
module debug_unit_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_WORDS  = 64,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  wire logic        i_clock,
    input  wire logic        i_reset,
    debug_unit_ctrl_if.slave bus
);

    // Host command bytes
    localparam logic [7:0] c_CMD_LOAD = 8'h4C;   // 'L'
    localparam logic [7:0] c_CMD_CONT = 8'h43;   // 'C'
    localparam logic [7:0] c_CMD_STEP = 8'h53;   // 'S'
    localparam logic [7:0] c_CMD_NEXT = 8'h4E;   // 'N'
    localparam logic [7:0] c_CMD_QUIT = 8'h51;   // 'Q'

    // Word counter must be able to hold MEM_WORDS itself
    localparam int                  c_WCNT_W    = $clog2(MEM_WORDS + 1);
    localparam logic [c_WCNT_W-1:0] c_MEM_WORDS = c_WCNT_W'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WRITE     = 3'd2,
        S_RUN       = 3'd3,
        S_STEP_WAIT = 3'd4,
        S_STEP_EXEC = 3'd5,
        S_STEP_SNAP = 3'd6,
        S_SEND      = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [DATA_WIDTH-1:0] r_instr;      // word being assembled / written
    logic [DATA_WIDTH-1:0] r_addr;       // byte address of the current word
    logic [c_WCNT_W-1:0]   r_words;      // words written during this load
    logic [c_WCNT_W-1:0]   r_prog_len;   // length of last good program, 0 = none
    logic [1:0]            r_byte_idx;   // byte position in LOAD and SEND
    logic [DATA_WIDTH-1:0] r_cnt;        // enabled-cycle counter
    logic [DATA_WIDTH-1:0] r_snap;       // value being reported
    logic                  r_finish;     // report ends execution (halt seen)
    logic                  r_done;
    logic                  r_load_err;

    logic                  w_rx_ready;
    logic                  w_rx_fire;
    logic                  w_tx_valid;
    logic                  w_tx_fire;
    logic                  w_loading;
    logic                  w_enable;
    logic [7:0]            w_tx_byte;
    logic [c_WCNT_W-1:0]   w_words_inc;
    logic [DATA_WIDTH-1:0] w_cnt_inc;
    logic                  w_is_halt_word;

    assign w_rx_ready     = (r_state == S_IDLE) || (r_state == S_LOAD) ||
                            (r_state == S_STEP_WAIT);
    assign w_tx_valid     = (r_state == S_SEND);
    assign w_rx_fire      = w_rx_ready && bus.i_rx_valid;
    assign w_tx_fire      = w_tx_valid && bus.i_tx_ready;
    assign w_words_inc    = r_words + c_WCNT_W'(1);
    assign w_is_halt_word = (r_instr == HALT_WORD);

    // Saturating increment: the count sticks at all-ones on overflow
    assign w_cnt_inc = (r_cnt == {DATA_WIDTH{1'b1}}) ? r_cnt
                                                    : r_cnt + DATA_WIDTH'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and per-state strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_loading = 1'b0;
        w_enable  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    if (bus.i_rx_data == c_CMD_LOAD) begin
                        w_next = S_LOAD;
                    end else if ((bus.i_rx_data == c_CMD_CONT) &&
                                 (r_prog_len != '0)) begin
                        w_next = S_RUN;
                    end else if ((bus.i_rx_data == c_CMD_STEP) &&
                                 (r_prog_len != '0)) begin
                        w_next = S_STEP_WAIT;
                    end
                end
            end

            S_LOAD: begin
                if (w_rx_fire && (r_byte_idx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end

            S_WRITE: begin
                w_loading = 1'b1;
                if (w_is_halt_word || (w_words_inc == c_MEM_WORDS)) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_LOAD;
                end
            end

            S_RUN: begin
                w_enable = 1'b1;
                if (bus.i_halt) begin
                    w_next = S_SEND;
                end
            end

            S_STEP_WAIT: begin
                if (w_rx_fire) begin
                    if (bus.i_rx_data == c_CMD_NEXT) begin
                        w_next = S_STEP_EXEC;
                    end else if (bus.i_rx_data == c_CMD_QUIT) begin
                        w_next = S_IDLE;
                    end
                end
            end

            S_STEP_EXEC: begin
                w_enable = 1'b1;
                w_next   = S_STEP_SNAP;
            end

            // One cycle to let the write-back value settle after the step
            S_STEP_SNAP: begin
                w_next = S_SEND;
            end

            S_SEND: begin
                if (w_tx_fire && (r_byte_idx == 2'd3)) begin
                    w_next = r_finish ? S_IDLE : S_STEP_WAIT;
                end
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_instr    <= '0;
            r_addr     <= '0;
            r_words    <= '0;
            r_prog_len <= '0;
            r_byte_idx <= 2'd0;
            r_cnt      <= '0;
            r_snap     <= '0;
            r_finish   <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        if (bus.i_rx_data == c_CMD_LOAD) begin
                            // A new load invalidates the previous program
                            r_instr    <= '0;
                            r_addr     <= '0;
                            r_words    <= '0;
                            r_prog_len <= '0;
                            r_byte_idx <= 2'd0;
                            r_load_err <= 1'b0;
                        end else if ((bus.i_rx_data == c_CMD_CONT) &&
                                     (r_prog_len != '0)) begin
                            r_cnt <= '0;
                        end
                    end
                end

                S_LOAD: begin
                    if (w_rx_fire) begin
                        r_instr    <= {r_instr[DATA_WIDTH-9:0], bus.i_rx_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end

                S_WRITE: begin
                    r_addr  <= r_addr + DATA_WIDTH'(4);
                    r_words <= w_words_inc;
                    if (w_is_halt_word) begin
                        r_prog_len <= w_words_inc;
                    end else if (w_words_inc == c_MEM_WORDS) begin
                        r_load_err <= 1'b1;
                        r_prog_len <= '0;
                    end
                end

                S_RUN: begin
                    r_cnt <= w_cnt_inc;
                    if (bus.i_halt) begin
                        // The halting cycle is itself an enabled cycle
                        r_snap     <= w_cnt_inc;
                        r_finish   <= 1'b1;
                        r_byte_idx <= 2'd0;
                    end
                end

                S_STEP_EXEC: begin
                    r_cnt    <= w_cnt_inc;
                    r_finish <= bus.i_halt;
                end

                S_STEP_SNAP: begin
                    r_snap     <= bus.i_result;
                    r_byte_idx <= 2'd0;
                end

                S_SEND: begin
                    if (w_tx_fire) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_done <= r_finish;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // Report byte selection, MSB first
    always_comb begin
        w_tx_byte = 8'h00;
        case (r_byte_idx)
            2'd0:    w_tx_byte = r_snap[31:24];
            2'd1:    w_tx_byte = r_snap[23:16];
            2'd2:    w_tx_byte = r_snap[15:8];
            default: w_tx_byte = r_snap[7:0];
        endcase
    end

    // Ready is masked during reset so every output reads 0 while it is held
    assign bus.o_rx_ready    = w_rx_ready && !i_reset;
    assign bus.o_tx_valid    = w_tx_valid;
    assign bus.o_tx_data     = w_tx_byte;
    assign bus.o_instruccion = r_instr;
    assign bus.o_address     = r_addr;
    assign bus.o_loading     = w_loading;
    assign bus.o_enable      = w_enable;
    assign bus.o_done        = r_done;
    assign bus.o_load_err    = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_debug_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_unit_ctrl
// Purpose  : Directed self-checking bench for debug_unit_ctrl. Instance A
//            uses the default memory depth; instance B uses MEM_WORDS=2 to
//            exercise the load overflow path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_unit_ctrl;

    logic clk;
    logic rst;

    int tests;
    int fails;

    debug_unit_ctrl_if #(.DATA_WIDTH(32)) ifa ();
    debug_unit_ctrl_if #(.DATA_WIDTH(32)) ifb ();

    debug_unit_ctrl #(.DATA_WIDTH(32), .MEM_WORDS(64), .HALT_WORD(32'hFFFFFFFF)) dut_a (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (ifa)
    );

    debug_unit_ctrl #(.DATA_WIDTH(32), .MEM_WORDS(2), .HALT_WORD(32'hFFFFFFFF)) dut_b (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitors, sampled on the falling edge
    logic [31:0] ld_word [16];
    logic [31:0] ld_addr [16];
    logic [7:0]  tx_byte [16];
    int ld_n, en_n, tx_n, done_n, ldb_n, enb_n;

    always @(negedge clk) begin
        if (ifa.o_loading) begin
            if (ld_n < 16) begin
                ld_word[ld_n] = ifa.o_instruccion;
                ld_addr[ld_n] = ifa.o_address;
            end
            ld_n++;
        end
        if (ifa.o_enable) en_n++;
        if (ifa.o_tx_valid && ifa.i_tx_ready) begin
            if (tx_n < 16) tx_byte[tx_n] = ifa.o_tx_data;
            tx_n++;
        end
        if (ifa.o_done) done_n++;
        if (ifb.o_loading) ldb_n++;
        if (ifb.o_enable) enb_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input bit to_b, input logic [7:0] d);
        logic acc;
        logic rdy;
        acc = 1'b0;
        if (to_b) begin
            ifb.i_rx_data  = d;
            ifb.i_rx_valid = 1'b1;
        end else begin
            ifa.i_rx_data  = d;
            ifa.i_rx_valid = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            rdy = to_b ? ifb.o_rx_ready : ifa.o_rx_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        ifa.i_rx_valid = 1'b0;
        ifb.i_rx_valid = 1'b0;
        if (!acc) check("rx_accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_tx(input int target, input string tag);
        for (int k = 0; k < 60 && tx_n < target; k++) cyc(1);
        check(tag, tx_n, target);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int k = 0; k < 60 && done_n < target; k++) cyc(1);
        check(tag, done_n, target);
    endtask

    initial begin
        int n;
        int k;
        logic stable;

        tests = 0;
        fails = 0;
        ld_n = 0; en_n = 0; tx_n = 0; done_n = 0; ldb_n = 0; enb_n = 0;
        rst = 1'b1;
        ifa.i_rx_data = 8'h00; ifa.i_rx_valid = 1'b0; ifa.i_tx_ready = 1'b1;
        ifa.i_halt = 1'b0;     ifa.i_result = 32'h0;
        ifb.i_rx_data = 8'h00; ifb.i_rx_valid = 1'b0; ifb.i_tx_ready = 1'b1;
        ifb.i_halt = 1'b0;     ifb.i_result = 32'h0;

        // ---------------- reset state ----------------
        cyc(3);
        check("reset_outputs",
              {ifa.o_rx_ready, ifa.o_tx_valid, ifa.o_loading, ifa.o_enable,
               ifa.o_done, ifa.o_load_err, 26'd0}, 32'h0);
        check("reset_addr", ifa.o_address, 32'h0);
        check("reset_instr", ifa.o_instruccion, 32'h0);
        rst = 1'b0;
        cyc(1);
        check("idle_rx_ready", {31'd0, ifa.o_rx_ready}, 32'd1);

        // 'C' with no program is ignored
        send_byte(1'b0, 8'h43);
        cyc(3);
        check("cont_no_prog_enable", en_n, 0);

        // ---------------- load, MEM_WORDS=2 overflow (instance B) ----------------
        send_byte(1'b1, 8'h4C);
        send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22); send_byte(1'b1, 8'h33); send_byte(1'b1, 8'h44);
        send_byte(1'b1, 8'h55); send_byte(1'b1, 8'h66); send_byte(1'b1, 8'h77); send_byte(1'b1, 8'h88);
        send_byte(1'b1, 8'h99); send_byte(1'b1, 8'hAA); send_byte(1'b1, 8'hBB); send_byte(1'b1, 8'hCC);
        cyc(2);
        check("ovf_loading_pulses", ldb_n, 2);
        check("ovf_load_err", {31'd0, ifb.o_load_err}, 32'd1);
        send_byte(1'b1, 8'h43);
        cyc(5);
        check("ovf_cont_ignored", enb_n, 0);
        send_byte(1'b1, 8'h4C);
        cyc(1);
        check("ovf_err_cleared_by_L", {31'd0, ifb.o_load_err}, 32'd0);

        // ---------------- load program (instance A) ----------------
        send_byte(1'b0, 8'h4C);
        send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h20);
        send_byte(1'b0, 8'hFF); send_byte(1'b0, 8'hFF); send_byte(1'b0, 8'hFF); send_byte(1'b0, 8'hFF);
        cyc(2);
        check("load_pulses", ld_n, 2);
        check("load_word0", ld_word[0], 32'h00000020);
        check("load_addr0", ld_addr[0], 32'h0);
        check("load_word1", ld_word[1], 32'hFFFFFFFF);
        check("load_addr1", ld_addr[1], 32'h4);
        check("load_err_clear", {31'd0, ifa.o_load_err}, 32'd0);
        check("load_idle_ready", {31'd0, ifa.o_rx_ready}, 32'd1);

        // ---------------- continuous run, halt on 10th enabled cycle ----------------
        en_n = 0; tx_n = 0; done_n = 0;
        send_byte(1'b0, 8'h43);
        n = 0;
        k = 0;
        while (n < 10 && k < 100) begin
            if (ifa.o_enable) n++;
            if (n < 10) cyc(1);
            k++;
        end
        ifa.i_halt = 1'b1;
        cyc(1);
        ifa.i_halt = 1'b0;
        wait_done(1, "run_done_pulse");
        cyc(2);
        check("run_enable_cycles", en_n, 10);
        check("run_tx_count", tx_n, 4);
        check("run_report", {tx_byte[0], tx_byte[1], tx_byte[2], tx_byte[3]}, 32'h0000000A);
        check("run_done_once", done_n, 1);

        // ---------------- step mode ----------------
        en_n = 0; tx_n = 0; done_n = 0;
        send_byte(1'b0, 8'h53);
        ifa.i_result = 32'h12345678;
        send_byte(1'b0, 8'h4E);
        wait_tx(4, "step_tx_count");
        cyc(2);
        check("step_enable_cycles", en_n, 1);
        check("step_report", {tx_byte[0], tx_byte[1], tx_byte[2], tx_byte[3]}, 32'h12345678);
        check("step_no_done", done_n, 0);
        check("step_wait_ready", {31'd0, ifa.o_rx_ready}, 32'd1);

        // Unknown byte in STEP_WAIT is ignored
        send_byte(1'b0, 8'h41);
        cyc(3);
        check("step_ignore_enable", en_n, 1);
        check("step_ignore_tx", tx_n, 4);

        // Final step with halt
        ifa.i_result = 32'hCAFEF00D;
        ifa.i_halt   = 1'b1;
        send_byte(1'b0, 8'h4E);
        cyc(1);
        ifa.i_halt = 1'b0;
        wait_done(1, "step_halt_done");
        check("step_halt_report", {tx_byte[4], tx_byte[5], tx_byte[6], tx_byte[7]}, 32'hCAFEF00D);
        check("step_halt_enable", en_n, 2);

        // Unknown byte in IDLE is ignored
        cyc(2);
        send_byte(1'b0, 8'h99);
        cyc(3);
        check("idle_ignore_state",
              {ifa.o_rx_ready, ifa.o_enable, ifa.o_tx_valid, ifa.o_loading, 28'd0},
              {4'b1000, 28'd0});
        check("idle_ignore_tx", tx_n, 8);

        // ---------------- back-pressure and reset mid-SEND ----------------
        en_n = 0; tx_n = 0; done_n = 0;
        ifa.i_tx_ready = 1'b0;
        ifa.i_result   = 32'hA1B2C3D4;
        send_byte(1'b0, 8'h53);
        send_byte(1'b0, 8'h4E);
        for (int j = 0; j < 20 && !ifa.o_tx_valid; j++) cyc(1);
        stable = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (!(ifa.o_tx_valid === 1'b1 && ifa.o_tx_data === 8'hA1)) stable = 1'b0;
            cyc(1);
        end
        check("bp_stable_hold", {31'd0, stable}, 32'd1);
        ifa.i_tx_ready = 1'b1;
        for (int j = 0; j < 20 && tx_n < 2; j++) cyc(1);
        check("bp_first_bytes", {tx_byte[0], tx_byte[1]}, 16'hA1B2);
        check("bp_third_byte_pending", {24'd0, ifa.o_tx_data}, 32'h000000C3);
        rst = 1'b1;
        ifa.i_tx_ready = 1'b0;
        cyc(1);
        check("midsend_reset_outputs",
              {ifa.o_rx_ready, ifa.o_tx_valid, ifa.o_loading, ifa.o_enable,
               ifa.o_done, ifa.o_load_err, ifa.o_tx_data, 18'd0}, 32'h0);
        check("midsend_reset_addr", ifa.o_address, 32'h0);
        rst = 1'b0;
        ifa.i_tx_ready = 1'b1;
        cyc(1);
        check("midsend_idle_ready", {31'd0, ifa.o_rx_ready}, 32'd1);
        send_byte(1'b0, 8'h43);
        cyc(4);
        check("post_reset_no_prog", en_n, 1);
        check("post_reset_tx", tx_n, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
